// File: rtl/pulse_decoder.sv
// Measures a burst on an asynchronous pulse line and classifies it as
// single, double or error, reporting with a one-cycle done strobe.
module pulse_decoder #(
    parameter int W       = 8,
    parameter int GAP_MAX = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sig_in,
    output logic         done,
    output logic [1:0]   kind,
    output logic [W-1:0] width1,
    output logic [W-1:0] gap,
    output logic [W-1:0] width2
);

    typedef enum logic [2:0] {
        IDLE,
        HIGH1,
        LOW1,
        HIGH2,
        TAIL,
        ERR_WAIT
    } state_t;

    localparam logic [1:0]   KIND_SINGLE = 2'b01;
    localparam logic [1:0]   KIND_DOUBLE = 2'b10;
    localparam logic [1:0]   KIND_ERROR  = 2'b11;
    localparam logic [W-1:0] CNT_MAX     = '1;
    localparam logic [W-1:0] CNT_ONE     = W'(1);
    localparam logic [W:0]   GAP_LIM     = (W+1)'(GAP_MAX);

    logic [1:0]   sync_reg;
    logic         sig_s;
    state_t       state_reg;
    logic [W-1:0] cnt_reg;
    logic [W-1:0] w1_lat_reg;
    logic [W-1:0] gap_lat_reg;
    logic [W-1:0] w2_lat_reg;
    logic [W:0]   cnt_inc;
    logic         gap_hit;

    assign sig_s   = sync_reg[1];
    // One extra bit so the GAP_MAX compare cannot wrap at cnt == 2^W-1.
    assign cnt_inc = {1'b0, cnt_reg} + 1'b1;
    assign gap_hit = (cnt_inc == GAP_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], sig_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            w1_lat_reg  <= '0;
            gap_lat_reg <= '0;
            w2_lat_reg  <= '0;
            done        <= 1'b0;
            kind        <= 2'b00;
            width1      <= '0;
            gap         <= '0;
            width2      <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (sig_s) begin
                        state_reg   <= HIGH1;
                        cnt_reg     <= CNT_ONE;
                        w1_lat_reg  <= '0;
                        gap_lat_reg <= '0;
                        w2_lat_reg  <= '0;
                    end
                end
                HIGH1: begin
                    if (sig_s) begin
                        if (cnt_reg == CNT_MAX) begin
                            done      <= 1'b1;
                            kind      <= KIND_ERROR;
                            width1    <= w1_lat_reg;
                            gap       <= gap_lat_reg;
                            width2    <= w2_lat_reg;
                            state_reg <= ERR_WAIT;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else begin
                        w1_lat_reg <= cnt_reg;
                        state_reg  <= LOW1;
                        cnt_reg    <= CNT_ONE;
                    end
                end
                LOW1: begin
                    if (sig_s) begin
                        gap_lat_reg <= cnt_reg;
                        state_reg   <= HIGH2;
                        cnt_reg     <= CNT_ONE;
                    end else if (gap_hit) begin
                        done      <= 1'b1;
                        kind      <= KIND_SINGLE;
                        width1    <= w1_lat_reg;
                        gap       <= '0;
                        width2    <= '0;
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                HIGH2: begin
                    if (sig_s) begin
                        if (cnt_reg == CNT_MAX) begin
                            done      <= 1'b1;
                            kind      <= KIND_ERROR;
                            width1    <= w1_lat_reg;
                            gap       <= gap_lat_reg;
                            width2    <= w2_lat_reg;
                            state_reg <= ERR_WAIT;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else begin
                        w2_lat_reg <= cnt_reg;
                        state_reg  <= TAIL;
                        cnt_reg    <= CNT_ONE;
                    end
                end
                TAIL: begin
                    if (sig_s) begin
                        done      <= 1'b1;
                        kind      <= KIND_ERROR;
                        width1    <= w1_lat_reg;
                        gap       <= gap_lat_reg;
                        width2    <= w2_lat_reg;
                        state_reg <= ERR_WAIT;
                        cnt_reg   <= '0;
                    end else if (gap_hit) begin
                        done      <= 1'b1;
                        kind      <= KIND_DOUBLE;
                        width1    <= w1_lat_reg;
                        gap       <= gap_lat_reg;
                        width2    <= w2_lat_reg;
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ERR_WAIT: begin
                    // Any high sample restarts the quiet-time count.
                    if (sig_s) begin
                        cnt_reg <= '0;
                    end else if (gap_hit) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule
